// File: rtl/half_adder_reg_if.sv
// Bundle of operand, qualifier and result signals for half_adder_reg.
// master drives the operands; slave is the half adder itself.
interface half_adder_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic             out_valid;

    modport master (
        output a, b, in_valid,
        input  s, c, s_q, c_q, out_valid
    );

    modport slave (
        input  a, b, in_valid,
        output s, c, s_q, c_q, out_valid
    );
endinterface

// File: rtl/half_adder_reg.sv
// Bitwise half adder: WIDTH independent lanes with a combinational result and
// an optional one-cycle registered copy qualified by out_valid.
module half_adder_reg #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input logic            clk,
    input logic            rst,
    half_adder_reg_if.slave bus
);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;

    // Lane-wise sum and carry; no carry ripples between lanes.
    assign sum   = bus.a ^ bus.b;
    assign carry = bus.a & bus.b;

    // The combinational outputs ignore clk and rst entirely.
    assign bus.s = sum;
    assign bus.c = carry;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] s_q_r;
            logic [WIDTH-1:0] c_q_r;
            logic             out_valid_r;

            // Capture on in_valid, otherwise hold; out_valid follows in_valid with one cycle delay.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q_r       <= '0;
                    c_q_r       <= '0;
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r <= bus.in_valid;
                    if (bus.in_valid) begin
                        s_q_r <= sum;
                        c_q_r <= carry;
                    end
                end
            end

            assign bus.s_q       = s_q_r;
            assign bus.c_q       = c_q_r;
            assign bus.out_valid = out_valid_r;
        end else begin : g_noreg
            // Registered path disabled: outputs tied low, no flops.
            logic unused_ok;
            assign unused_ok     = clk ^ rst ^ bus.in_valid;
            assign bus.s_q       = '0;
            assign bus.c_q       = '0;
            assign bus.out_valid = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_half_adder_reg.sv
// Directed self-checking bench for half_adder_reg: WIDTH=1 and WIDTH=8 with
// registered outputs, plus WIDTH=8 with the registered path disabled.
module tb_half_adder_reg;
    logic clk;
    logic rst;
    logic clk_run;
    int   n_checks;
    int   n_fail;

    half_adder_reg_if #(.WIDTH(1)) bus1 ();
    half_adder_reg_if #(.WIDTH(8)) bus8 ();
    half_adder_reg_if #(.WIDTH(8)) bus0 ();

    half_adder_reg #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (.clk(clk), .rst(rst), .bus(bus1));
    half_adder_reg #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (.clk(clk), .rst(rst), .bus(bus8));
    half_adder_reg #(.WIDTH(8), .REG_OUT(1'b0)) u_w0 (.clk(clk), .rst(rst), .bus(bus0));

    // Clock is held low until clk_run is set so the combinational test sees an idle clock.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb_idle();
        bus1.a = 1'b0; bus1.b = 1'b0;
        #1;
        n_checks++; if ({bus1.s, bus1.c} !== 2'b00) begin n_fail++; $display("FAIL comb_t0: got s,c=%b expected 00", {bus1.s, bus1.c}); end
        #9;
        bus1.a = 1'b1; bus1.b = 1'b0;
        #1;
        n_checks++; if ({bus1.s, bus1.c} !== 2'b10) begin n_fail++; $display("FAIL comb_t10: got s,c=%b expected 10", {bus1.s, bus1.c}); end
        #14;
        bus1.a = 1'b1; bus1.b = 1'b1;
        #1;
        n_checks++; if ({bus1.s, bus1.c} !== 2'b01) begin n_fail++; $display("FAIL comb_t25: got s,c=%b expected 01", {bus1.s, bus1.c}); end
        #19;
        bus1.a = 1'b1; bus1.b = 1'b0;
        #1;
        n_checks++; if ({bus1.s, bus1.c} !== 2'b10) begin n_fail++; $display("FAIL comb_t45: got s,c=%b expected 10", {bus1.s, bus1.c}); end
        #99;
        n_checks++; if ({bus1.s, bus1.c} !== 2'b10) begin n_fail++; $display("FAIL comb_hold: got s,c=%b expected 10", {bus1.s, bus1.c}); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++; if ({bus1.s_q, bus1.c_q, bus1.out_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_w1: got %b expected 000", {bus1.s_q, bus1.c_q, bus1.out_valid}); end
        n_checks++; if ({bus8.s_q, bus8.c_q, bus8.out_valid} !== 17'h0) begin n_fail++; $display("FAIL reset_w8: got %h expected 0", {bus8.s_q, bus8.c_q, bus8.out_valid}); end
        clk_run = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_ov: got %b expected 0", bus8.out_valid); end
    endtask

    task automatic test_exhaustive_w1();
        logic [3:0] exp_s;
        logic [3:0] exp_c;
        exp_s = 4'b0110;  // index {a,b}: 00,01,10,11
        exp_c = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            bus1.a = i[1]; bus1.b = i[0]; bus1.in_valid = 1'b1;
            #1;
            n_checks++; if ({bus1.s, bus1.c} !== {exp_s[i], exp_c[i]}) begin n_fail++; $display("FAIL w1_comb ab=%0d: got %b expected %b", i, {bus1.s, bus1.c}, {exp_s[i], exp_c[i]}); end
            tick();
            n_checks++; if ({bus1.s_q, bus1.c_q, bus1.out_valid} !== {exp_s[i], exp_c[i], 1'b1}) begin n_fail++; $display("FAIL w1_reg ab=%0d: got %b expected %b", i, {bus1.s_q, bus1.c_q, bus1.out_valid}, {exp_s[i], exp_c[i], 1'b1}); end
        end
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_width8();
        bus8.a = 8'hF0; bus8.b = 8'h3C; bus8.in_valid = 1'b1;
        #1;
        n_checks++; if ({bus8.s, bus8.c} !== 16'hCC30) begin n_fail++; $display("FAIL w8_comb_f0_3c: got %h expected cc30", {bus8.s, bus8.c}); end
        tick();
        n_checks++; if ({bus8.s_q, bus8.c_q, bus8.out_valid} !== {16'hCC30, 1'b1}) begin n_fail++; $display("FAIL w8_reg_f0_3c: got %h expected %h", {bus8.s_q, bus8.c_q, bus8.out_valid}, {16'hCC30, 1'b1}); end
        bus8.a = 8'hFF; bus8.b = 8'hFF;
        #1;
        n_checks++; if ({bus8.s, bus8.c} !== 16'h00FF) begin n_fail++; $display("FAIL w8_comb_ff_ff: got %h expected 00ff", {bus8.s, bus8.c}); end
        tick();
        n_checks++; if ({bus8.s_q, bus8.c_q, bus8.out_valid} !== {16'h00FF, 1'b1}) begin n_fail++; $display("FAIL w8_reg_ff_ff: got %h expected %h", {bus8.s_q, bus8.c_q, bus8.out_valid}, {16'h00FF, 1'b1}); end
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_valid_gating();
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.in_valid = 1'b1;
        tick();
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.in_valid = 1'b0;
        n_checks++; if ({bus1.s_q, bus1.c_q, bus1.out_valid} !== 3'b011) begin n_fail++; $display("FAIL gate_capture: got %b expected 011", {bus1.s_q, bus1.c_q, bus1.out_valid}); end
        tick();
        n_checks++; if ({bus1.s_q, bus1.c_q, bus1.out_valid} !== 3'b010) begin n_fail++; $display("FAIL gate_hold: got %b expected 010", {bus1.s_q, bus1.c_q, bus1.out_valid}); end
        n_checks++; if ({bus1.s, bus1.c} !== 2'b10) begin n_fail++; $display("FAIL gate_comb: got %b expected 10", {bus1.s, bus1.c}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] es [4];
        logic [7:0] ec [4];
        va = '{8'h00, 8'h5A, 8'hC3, 8'h81};
        vb = '{8'hFF, 8'h5A, 8'h0F, 8'h18};
        es = '{8'hFF, 8'h00, 8'hCC, 8'h99};
        ec = '{8'h00, 8'h5A, 8'h03, 8'h00};
        for (int i = 0; i < 4; i++) begin
            bus8.a = va[i]; bus8.b = vb[i]; bus8.in_valid = 1'b1;
            tick();
            n_checks++; if ({bus8.s_q, bus8.c_q, bus8.out_valid} !== {es[i], ec[i], 1'b1}) begin n_fail++; $display("FAIL b2b_%0d: got %h expected %h", i, {bus8.s_q, bus8.c_q, bus8.out_valid}, {es[i], ec[i], 1'b1}); end
        end
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        bus8.a = 8'hAA; bus8.b = 8'h0F; bus8.in_valid = 1'b1;
        tick();
        n_checks++; if ({bus8.s_q, bus8.c_q, bus8.out_valid} !== {8'hA5, 8'h0A, 1'b1}) begin n_fail++; $display("FAIL arst_pre: got %h expected %h", {bus8.s_q, bus8.c_q, bus8.out_valid}, {8'hA5, 8'h0A, 1'b1}); end
        #2;
        rst = 1'b1;
        bus8.a = 8'h33; bus8.b = 8'h11;
        #1;
        n_checks++; if ({bus8.s_q, bus8.c_q, bus8.out_valid} !== 17'h0) begin n_fail++; $display("FAIL arst_async_clear: got %h expected 0", {bus8.s_q, bus8.c_q, bus8.out_valid}); end
        n_checks++; if ({bus8.s, bus8.c} !== 16'h2211) begin n_fail++; $display("FAIL arst_comb: got %h expected 2211", {bus8.s, bus8.c}); end
        tick();
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_held: got %b expected 0", bus8.out_valid); end
        #2;
        rst = 1'b0;
        bus8.in_valid = 1'b0;
        tick();
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_release_idle: got %b expected 0", bus8.out_valid); end
        bus8.a = 8'h03; bus8.b = 8'h01; bus8.in_valid = 1'b1;
        tick();
        n_checks++; if ({bus8.s_q, bus8.c_q, bus8.out_valid} !== {8'h02, 8'h01, 1'b1}) begin n_fail++; $display("FAIL arst_first_result: got %h expected %h", {bus8.s_q, bus8.c_q, bus8.out_valid}, {8'h02, 8'h01, 1'b1}); end
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_reg_out0();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] es [3];
        logic [7:0] ec [3];
        va = '{8'hF0, 8'hFF, 8'h96};
        vb = '{8'h3C, 8'hFF, 8'h69};
        es = '{8'hCC, 8'h00, 8'hFF};
        ec = '{8'h30, 8'hFF, 8'h00};
        for (int i = 0; i < 3; i++) begin
            bus0.a = va[i]; bus0.b = vb[i]; bus0.in_valid = 1'b1;
            #1;
            n_checks++; if ({bus0.s, bus0.c} !== {es[i], ec[i]}) begin n_fail++; $display("FAIL r0_comb_%0d: got %h expected %h", i, {bus0.s, bus0.c}, {es[i], ec[i]}); end
            tick();
            n_checks++; if ({bus0.s_q, bus0.c_q, bus0.out_valid} !== 17'h0) begin n_fail++; $display("FAIL r0_regs_%0d: got %h expected 0", i, {bus0.s_q, bus0.c_q, bus0.out_valid}); end
        end
        bus0.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        clk_run  = 1'b0;
        rst      = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.in_valid = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.in_valid = 1'b0;
        bus0.a = '0; bus0.b = '0; bus0.in_valid = 1'b0;

        test_comb_idle();
        test_reset();
        test_exhaustive_w1();
        test_width8();
        test_valid_gating();
        test_back_to_back();
        test_async_reset();
        test_reg_out0();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/half_adder_reg.md
Name:
half_adder_reg

Overview:
- Parameterised bitwise half adder: one independent half adder per bit of `a` and `b`.
- `s` and `c` are purely combinational and independent of clock and reset.
- A registered copy of the results, with a valid flag, is provided for pipelined consumers.
- Used as a leaf arithmetic cell and as a registered stage in adder datapaths.

Parameters:
- WIDTH, 1, number of independent half-adder bit lanes (must be at least 1).
- REG_OUT, 1, 1 = registered outputs active; 0 = `s_q`/`c_q`/`out_valid` tied to 0.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies `a`/`b` for the registered path.
- s  output  WIDTH  combinational sum, `a ^ b`.
- c  output  WIDTH  combinational carry, `a & b`.
- s_q  output  WIDTH  registered sum.
- c_q  output  WIDTH  registered carry.
- out_valid  output  1  registered `s_q`/`c_q` hold a valid result.

Behaviour:
- Combinational path:
  - `s[i] = a[i] XOR b[i]` and `c[i] = a[i] AND b[i]` for every lane i.
  - Zero latency.
  - Unaffected by `clk` or `rst`, so the path works with `clk`/`rst` unconnected or held.
  - Truth table per lane (a,b -> s,c): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Lanes are independent. There is no carry propagation between bits.
- Registered path (REG_OUT=1):
  - On a rising `clk` edge with `rst` low:
    - `out_valid <= in_valid`.
    - If `in_valid` = 1: `s_q <= a ^ b` and `c_q <= a & b`.
    - If `in_valid` = 0: `s_q`/`c_q` hold their previous value.
  - Latency is exactly 1 cycle from sampled inputs to `s_q`/`c_q`/`out_valid`.
  - There is no backpressure. A new result is accepted every cycle.
- Reset:
  - `rst` = 1 asynchronously forces `s_q` = 0, `c_q` = 0 and `out_valid` = 0, regardless of `clk`.
  - Deasserting `rst` takes effect at the next rising edge.
  - Reset in the middle of a stream drops the in-flight result. `out_valid` stays 0 until a cycle where `in_valid` is sampled high after reset release.
  - `s` and `c` keep tracking `a`/`b` during reset.
- REG_OUT=0: `s_q`, `c_q` and `out_valid` are constant 0, and no flops are inferred.
- X/Z on inputs propagate per standard operator semantics. No special handling.
- Invariant: per lane, `s[i]` and `c[i]` are never both 1. The same holds for `s_q`/`c_q`.

Test Plan:
- WIDTH=1, `clk`/`rst` idle: apply a=0,b=0 at t=0, a=1,b=0 at t=10, a=1,b=1 at t=25, a=1,b=0 at t=45 -> s,c = 0,0 / 1,0 / 0,1 / 1,0 immediately after each change; hold until t=145.
- WIDTH=1, exhaustive: apply all four a,b combinations -> the truth table above on `s`/`c`. In each cycle `in_valid`=1, so `s_q`/`c_q` match one cycle later and `out_valid`=1.
- WIDTH=8: a=8'hF0, b=8'h3C -> s=8'hCC, c=8'h30. a=8'hFF, b=8'hFF -> s=8'h00, c=8'hFF, with no carry between lanes.
- Valid gating: `in_valid`=1 with a=1,b=1 for one cycle, then `in_valid`=0 with a=1,b=0 -> the next cycle gives `s_q`=0, `c_q`=1, `out_valid`=1; the cycle after gives `out_valid`=0 with `s_q`/`c_q` still 0/1.
- Async reset: assert `rst` mid-cycle while `out_valid`=1 -> `s_q`, `c_q` and `out_valid` go to 0 before the next edge, while `s`/`c` still follow `a`/`b`. After release, the first result appears one edge after `in_valid`=1.
- REG_OUT=0: any stimulus -> `s_q`=0, `c_q`=0 and `out_valid`=0 at all times; `s`/`c` remain correct.
